bldc_setpoint_sequencer: RTL

- Run-time controller in front of the BLDC ESC datapath.
- Sequences the ESC through startup: tuner reset/autotune, then enable, then a ramped speed-period setpoint, then run.
- Also handles controlled stop and an optional stall watchdog.
- Drives the ESC's `pwm_en`, `period_reference` and `tunerreset_autotune` inputs, so the ESC never sees a step setpoint or an unsynchronised enable.

---
 rtl/bldc_seq_pkg.sv | 18 +
 rtl/bldc_seq_ramp_gen.sv | 28 ++
 rtl/bldc_setpoint_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bldc_seq_pkg.sv
// Shared types and constants for the BLDC setpoint sequencer.
// Holds the state encoding, the reverse-period limit, the ramp step and the default tick divider.
package bldc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_STOP  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam int unsigned REV_LIMIT    = 32766;
    localparam int          DEF_TICK_DIV = 65;
    localparam int          RAMP_STEP    = 256;

endpackage

// File: rtl/bldc_seq_ramp_gen.sv
// Saturating magnitude stepper: moves cur one step toward tgt on strobe, never overshooting.
// The same instance serves acceleration in RAMP and deceleration in STOP.
module bldc_ramp_gen #(
    parameter int W = 16
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] tgt,
    input  logic [W-1:0] step,
    input  logic         strobe,
    output logic [W-1:0] next,
    output logic         at_target
);

    always_comb begin
        next = cur;
        if (strobe) begin
            // Differences are taken in the safe direction only, so nothing wraps.
            if (cur > tgt) begin
                next = ((cur - tgt) > step) ? (cur - step) : tgt;
            end else if (cur < tgt) begin
                next = ((tgt - cur) > step) ? (cur + step) : tgt;
            end
        end
    end

    assign at_target = (cur == tgt);

endmodule

// File: rtl/bldc_setpoint_sequencer.sv
// Startup/stop sequencer in front of the BLDC ESC: tuner reset, enable, ramped period, run.
// Define BLDC_SEQ_STALL_WATCHDOG_EN to add the encoder stall watchdog and the FAULT path.
module bldc_setpoint_sequencer
    import bldc_seq_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    TICK_DIV     = DEF_TICK_DIV,
    parameter int                    RAMP_DIV     = 16,
    parameter logic [DATA_WIDTH-1:0] START_PERIOD = DATA_WIDTH'(30000),
    parameter int                    ARM_TICKS    = 4,
    parameter int                    STALL_TICKS  = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear_fault,
    input  logic [DATA_WIDTH-1:0] target_period,
    input  logic                  target_dir,
    input  logic [2:0]            pid_select,
    input  logic                  encoder_a,
    output logic                  pwm_en,
    output logic [DATA_WIDTH-1:0] period_reference,
    output logic [3:0]            tunerreset_autotune,
    output logic                  busy,
    output logic                  fault,
    output logic [2:0]            state_o
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int RW = $clog2(RAMP_DIV + 1);
    localparam int AW = $clog2(ARM_TICKS + 1);
    localparam int SW = $clog2(STALL_TICKS + 1);
    localparam logic [TW-1:0]         TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0]         RAMP_LAST  = RW'(RAMP_DIV - 1);
    localparam logic [AW-1:0]         ARM_LAST   = AW'(ARM_TICKS - 1);
    localparam logic [SW-1:0]         STALL_LAST = SW'(STALL_TICKS);
    localparam logic [DATA_WIDTH-1:0] LP_REV_LIM = DATA_WIDTH'(REV_LIMIT);
    localparam logic [DATA_WIDTH-1:0] LP_STEP    = DATA_WIDTH'(RAMP_STEP);

    state_t                r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_mag, w_mag_next, w_tgt, w_ramp_tgt, w_ramp_next;
    logic [TW-1:0]         r_tick_cnt;
    logic [RW-1:0]         r_ramp_cnt;
    logic [AW-1:0]         r_arm_cnt;
    logic [2:0]            r_enc_sync;
    logic                  r_restart, w_restart_next, r_dir_q;
    logic                  w_tick, w_strobe, w_arm_done, w_at_target, w_dir_chg;
    logic                  w_enc_rise, w_stall, w_entering, w_ramping;
    logic                  r_pwm_en, r_busy, r_fault;
    logic [DATA_WIDTH-1:0] r_period_ref;
    logic [3:0]            r_tuner;

    function automatic logic [DATA_WIDTH-1:0] clamp_tgt(input logic [DATA_WIDTH-1:0] t);
        if (t == '0) begin
            return DATA_WIDTH'(1);
        end else if (t > LP_REV_LIM) begin
            return LP_REV_LIM;
        end
        return t;
    endfunction

    assign w_tgt      = clamp_tgt(target_period);
    assign w_ramp_tgt = (r_state == ST_STOP) ? START_PERIOD : w_tgt;
    assign w_ramping  = (r_state == ST_RAMP) || (r_state == ST_STOP);
    assign w_entering = (w_state_next != r_state);
    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_strobe   = w_ramping && w_tick && (r_ramp_cnt == RAMP_LAST);
    assign w_arm_done = w_tick && (r_arm_cnt == ARM_LAST);
    assign w_dir_chg  = (target_dir != r_dir_q);
    assign w_enc_rise = r_enc_sync[1] & ~r_enc_sync[2];

    bldc_ramp_gen #(.W(DATA_WIDTH)) u_ramp (
        .cur       (r_mag),
        .tgt       (w_ramp_tgt),
        .step      (LP_STEP),
        .strobe    (w_strobe),
        .next      (w_ramp_next),
        .at_target (w_at_target)
    );

    always_comb begin
        w_state_next   = r_state;
        w_mag_next     = r_mag;
        w_restart_next = r_restart;
        case (r_state)
            ST_IDLE: begin
                w_mag_next = START_PERIOD;
                if (!stop && (start || r_restart)) w_state_next = ST_ARM;
            end
            ST_ARM: begin
                w_restart_next = 1'b0;
                if (stop)            w_state_next = ST_IDLE;
                else if (w_arm_done) w_state_next = ST_RAMP;
            end
            ST_RAMP, ST_RUN: begin
                if (r_state == ST_RAMP) w_mag_next = w_ramp_next;
                if (w_stall) begin
                    w_state_next = ST_FAULT;
                end else if (stop) begin
                    w_state_next   = ST_STOP;
                    w_restart_next = 1'b0;
                end else if (w_dir_chg) begin
                    // Reversal always passes through a full stop, then re-arms by itself.
                    w_state_next   = ST_STOP;
                    w_restart_next = 1'b1;
                end else if (r_state == ST_RAMP && w_at_target) begin
                    w_state_next = ST_RUN;
                end else if (r_state == ST_RUN && !w_at_target) begin
                    w_state_next = ST_RAMP;
                end
            end
            ST_STOP: begin
                w_mag_next = w_ramp_next;
                if (stop) w_restart_next = 1'b0;
                if (w_stall)          w_state_next = ST_FAULT;
                else if (w_at_target) w_state_next = ST_IDLE;
            end
            ST_FAULT: begin
                if (clear_fault) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mag        <= START_PERIOD;
            r_tick_cnt   <= '0;
            r_ramp_cnt   <= '0;
            r_arm_cnt    <= '0;
            r_restart    <= 1'b0;
            r_dir_q      <= 1'b0;
            r_enc_sync   <= '0;
            r_pwm_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_period_ref <= '0;
            r_tuner      <= 4'b1000;
        end else begin
            r_state    <= w_state_next;
            r_mag      <= w_mag_next;
            r_restart  <= w_restart_next;
            r_dir_q    <= target_dir;
            r_enc_sync <= {r_enc_sync[1:0], encoder_a};
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_entering || !w_ramping) r_ramp_cnt <= '0;
            else if (w_strobe)            r_ramp_cnt <= '0;
            else if (w_tick)              r_ramp_cnt <= r_ramp_cnt + 1'b1;
            if (w_entering || r_state != ST_ARM) r_arm_cnt <= '0;
            else if (w_tick)                     r_arm_cnt <= r_arm_cnt + 1'b1;
            // Outputs follow the next state so every output moves on the same clk as the state.
            r_pwm_en <= (w_state_next inside {ST_RAMP, ST_RUN, ST_STOP});
            r_busy   <= !(w_state_next inside {ST_IDLE, ST_FAULT});
            r_fault  <= (w_state_next == ST_FAULT);
            r_tuner  <= {(w_state_next inside {ST_IDLE, ST_ARM, ST_FAULT}), pid_select};
            if (w_state_next inside {ST_IDLE, ST_FAULT}) r_period_ref <= '0;
            else if (target_dir)                         r_period_ref <= ~w_mag_next + 1'b1;
            else                                         r_period_ref <= w_mag_next;
        end
    end

`ifdef BLDC_SEQ_STALL_WATCHDOG_EN
    logic [SW-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!(r_state inside {ST_RAMP, ST_RUN, ST_STOP}) || w_enc_rise ||
                     (w_state_next == ST_RAMP && r_state != ST_RAMP)) begin
            r_stall_cnt <= '0;
        end else if (w_tick && !w_stall) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign w_stall = (r_stall_cnt == STALL_LAST);
`else
    logic w_unused;
    assign w_stall  = 1'b0;
    assign w_unused = ^{w_enc_rise, STALL_LAST};
`endif

    assign pwm_en              = r_pwm_en;
    assign period_reference    = r_period_ref;
    assign tunerreset_autotune = r_tuner;
    assign busy                = r_busy;
    assign fault               = r_fault;
    assign state_o             = r_state;

endmodule
